// File: rtl/debounce_edge_detect_pkg.sv
// Shared types for the debouncer: per-bit FSM state encoding and counter sizing.
// Pure declarations; no logic, no latency, no flow control.
package debounce_edge_detect_pkg;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    CHK_HI = 2'd1,
    S_HI   = 2'd2,
    CHK_LO = 2'd3
  } db_state_e;

  // Counter only has to reach DB_CYCLES-1; clamp to one bit for tiny configs.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Bundle of the debouncer's per-bit level, pulse and sticky-flag buses.
// Wiring only; no latency, no backpressure.
interface debounce_edge_detect_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic             evt_any;

  // master drives raw levels and clears; slave is the debouncer side
  modport master (
    output din, clr,
    input  dout, rise, fall, evt, evt_any
  );

  modport slave (
    input  din, clr,
    output dout, rise, fall, evt, evt_any
  );
endinterface

// File: rtl/debounce_edge_detect_db_bit.sv
// One-bit debouncer FSM with registered level and one-cycle rise/fall pulses.
// dout moves DB_CYCLES-1 edges after the first new-level sample; no backpressure.
module db_bit
  import debounce_edge_detect_pkg::*;
#(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  db_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LO: begin
          if (din) begin
            state <= CHK_HI;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_HI: begin
          if (!din) begin
            state <= S_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // the DB_CYCLES-th consecutive high sample commits the level
            state <= S_HI;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!din) begin
            state <= CHK_LO;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        CHK_LO: begin
          if (din) begin
            state <= S_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LO;
          cnt   <= '0;
          dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_edge_detect.sv
// WIDTH independent debouncers with edge pulses and per-bit sticky event flags.
// Levels/pulses lag DB_CYCLES-1 edges, evt one edge more; free-running, no backpressure.
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  output logic             evt_any
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    db_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db_bit (
      .clk  (clk),
      .rstn (rstn),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // a new edge outranks a clear landing on the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~clr) | rise | fall;
    end
  end

  assign evt_any = |evt;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Scoreboard bench for debounce_edge_detect with WIDTH=4, DB_CYCLES=4.
module tb_debounce_edge_detect;

  localparam int WIDTH = 4;
  localparam int DBC   = 4;

  localparam int SEL_DOUT = 0;
  localparam int SEL_RISE = 1;
  localparam int SEL_FALL = 2;
  localparam int SEL_EVT  = 3;
  localparam int SEL_ANY  = 4;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [3:0]  val;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb[$];
  exp_t keep[$];

  debounce_edge_detect_if #(.WIDTH(WIDTH)) bus ();

  debounce_edge_detect #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DBC)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .din     (bus.din),
    .clr     (bus.clr),
    .dout    (bus.dout),
    .rise    (bus.rise),
    .fall    (bus.fall),
    .evt     (bus.evt),
    .evt_any (bus.evt_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      SEL_DOUT: return bus.dout;
      SEL_RISE: return bus.rise;
      SEL_FALL: return bus.fall;
      SEL_EVT:  return bus.evt;
      default:  return {3'b000, bus.evt_any};
    endcase
  endfunction

  // queue an expectation n edges from now
  task automatic expect_at(input int n, input string tag, input int sel, input logic [3:0] v);
    exp_t e;
    e.due = cyc + n;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // pop every expectation that falls due on this cycle
  always @(negedge clk) begin
    keep = {};
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due == cyc)
        check(sb[i].tag, {28'd0, observe(sb[i].sel)}, {28'd0, sb[i].val});
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_err    = 0;
    rstn     = 1'b0;
    bus.din  = 4'b1111;
    bus.clr  = 4'b0000;

    // reset holds everything low despite din high
    step(3);
    expect_at(0, "rst_dout", SEL_DOUT, 4'b0000);
    expect_at(0, "rst_rise", SEL_RISE, 4'b0000);
    expect_at(0, "rst_fall", SEL_FALL, 4'b0000);
    expect_at(0, "rst_evt",  SEL_EVT,  4'b0000);
    step(1);

    // release with din held: level commits on the 4th edge
    rstn = 1'b1;
    expect_at(1,   "rel_nopulse",  SEL_RISE, 4'b0000);
    expect_at(DBC-1, "rel_dout_pre", SEL_DOUT, 4'b0000);
    expect_at(DBC,   "rel_dout",     SEL_DOUT, 4'b1111);
    expect_at(DBC,   "rel_rise",     SEL_RISE, 4'b1111);
    expect_at(DBC,   "rel_evt_pre",  SEL_EVT,  4'b0000);
    expect_at(DBC+1, "rel_rise_off", SEL_RISE, 4'b0000);
    expect_at(DBC+1, "rel_evt",      SEL_EVT,  4'b1111);
    expect_at(DBC+1, "rel_any",      SEL_ANY,  4'b0001);
    step(DBC + 2);
    bus.clr = 4'b1111;
    expect_at(1, "clr_all", SEL_EVT, 4'b0000);
    step(1);
    bus.clr = 4'b0000;

    // falling edge on all bits (bit 2 included)
    bus.din = 4'b0000;
    expect_at(DBC-1, "fall_dout_pre", SEL_DOUT, 4'b1111);
    expect_at(DBC,   "fall_pulse",    SEL_FALL, 4'b1111);
    expect_at(DBC,   "fall_dout",     SEL_DOUT, 4'b0000);
    expect_at(DBC,   "fall_norise",   SEL_RISE, 4'b0000);
    expect_at(DBC+1, "fall_off",      SEL_FALL, 4'b0000);
    expect_at(DBC+1, "fall_evt",      SEL_EVT,  4'b1111);
    expect_at(DBC+1, "fall_any",      SEL_ANY,  4'b0001);
    step(DBC + 2);
    bus.clr = 4'b1111;
    step(1);
    bus.clr = 4'b0000;
    expect_at(0, "fall_any_clr", SEL_ANY, 4'b0000);
    step(1);

    // glitch: three high samples on bit 0 must be swallowed
    bus.din = 4'b0001;
    for (int k = 1; k <= DBC-1; k++) begin
      expect_at(k, "glitch_rise", SEL_RISE, 4'b0000);
      expect_at(k, "glitch_dout", SEL_DOUT, 4'b0000);
    end
    step(DBC - 1);
    bus.din = 4'b0000;
    for (int k = 1; k <= DBC; k++) begin
      expect_at(k, "glitch_rise_after", SEL_RISE, 4'b0000);
      expect_at(k, "glitch_dout_after", SEL_DOUT, 4'b0000);
    end
    step(DBC);
    expect_at(0, "glitch_evt", SEL_EVT, 4'b0000);
    step(1);

    // clear colliding with a new set on bit 1: set wins, then clear alone
    bus.din = 4'b0010;
    expect_at(DBC,   "col_rise",    SEL_RISE, 4'b0010);
    expect_at(DBC+1, "col_evt_set", SEL_EVT,  4'b0010);
    expect_at(DBC+2, "col_evt_clr", SEL_EVT,  4'b0000);
    expect_at(DBC+2, "col_any_clr", SEL_ANY,  4'b0000);
    step(DBC);
    bus.clr = 4'b0010;
    step(2);
    bus.clr = 4'b0000;

    // reset mid-count on bit 3 throws away the partial count
    bus.din = 4'b1010;
    step(2);
    rstn = 1'b0;
    expect_at(0, "mid_rst_dout", SEL_DOUT, 4'b0000);
    expect_at(0, "mid_rst_evt",  SEL_EVT,  4'b0000);
    step(1);
    rstn = 1'b1;
    expect_at(DBC-1, "mid_dout_pre", SEL_DOUT, 4'b0000);
    expect_at(DBC,   "mid_dout",     SEL_DOUT, 4'b1010);
    expect_at(DBC,   "mid_rise",     SEL_RISE, 4'b1010);
    step(DBC + 2);

    // independence: bits flip in opposite directions together
    expect_at(0, "ind_start", SEL_DOUT, 4'b1010);
    step(1);
    bus.din = 4'b0101;
    expect_at(DBC-1, "ind_dout_pre", SEL_DOUT, 4'b1010);
    expect_at(DBC,   "ind_rise",     SEL_RISE, 4'b0101);
    expect_at(DBC,   "ind_fall",     SEL_FALL, 4'b1010);
    expect_at(DBC,   "ind_dout",     SEL_DOUT, 4'b0101);
    expect_at(DBC+1, "ind_rise_off", SEL_RISE, 4'b0000);
    expect_at(DBC+1, "ind_evt",      SEL_EVT,  4'b1111);
    step(DBC + 3);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
